prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 136 +++++++++++++
 tb/tb_prefetch_queue.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches LANES-wide words into a circular buffer of
// {inst, pc} entries and issues one instruction per cycle through an output register.
module prefetch_queue #(
   parameter int unsigned   IW       = 16,
   parameter int unsigned   LANES    = 2,
   parameter int unsigned   DEPTH    = 8,
   parameter int unsigned   AW       = 32,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    fetch_req,
   output logic [AW-1:0]           fetch_addr,
   input  logic                    fetch_valid,
   input  logic [LANES*IW-1:0]     fetch_data,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [AW-1:0]           flush_pc,
   output logic [IW-1:0]           inst,
   output logic [AW-1:0]           inst_pc,
   output logic                    inst_valid,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned LW         = $clog2(DEPTH);
   localparam int unsigned PW         = LW + 1;
   localparam int unsigned INST_BYTES = IW / 8;
   localparam int unsigned WORD_BYTES = LANES * INST_BYTES;

   logic [IW-1:0] mem_inst_q [DEPTH];
   logic [AW-1:0] mem_pc_q   [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] fetch_addr_q, fetch_addr_d, req_addr_q, req_addr_d;
   logic [IW-1:0] inst_q, inst_d;
   logic [AW-1:0] inst_pc_q, inst_pc_d;
   logic          inst_valid_q, inst_valid_d;
   logic          pending_q, pending_d, discard_q, discard_d, started_q;

   logic [PW-1:0] count_w, free_w;
   logic          rsp_w, push_w, pop_w;

   // Pointers carry one extra wrap bit so full (count == DEPTH) and empty differ.
   assign count_w = wr_ptr_q - rd_ptr_q;
   assign free_w  = PW'(DEPTH) - count_w;

   assign rsp_w     = fetch_valid & pending_q;
   assign push_w    = rsp_w & ~discard_q & ~flush;
   assign pop_w     = ~flush & ~stall & (count_w != '0);
   assign fetch_req = started_q & ~pending_q & ~flush & (free_w >= PW'(LANES));

   // NOTE: every variable gets its default before any branch, so no latch is inferred.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fetch_addr_d = fetch_addr_q;
      req_addr_d   = req_addr_q;
      pending_d    = pending_q;
      discard_d    = discard_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;

      if (fetch_req) begin
         pending_d    = 1'b1;
         req_addr_d   = fetch_addr_q;
         fetch_addr_d = fetch_addr_q + AW'(WORD_BYTES);
      end
      if (rsp_w) begin
         pending_d = 1'b0;
         discard_d = 1'b0;
      end
      if (push_w) wr_ptr_d = wr_ptr_q + PW'(LANES);

      if (pop_w) begin
         rd_ptr_d     = rd_ptr_q + PW'(1);
         inst_d       = mem_inst_q[rd_ptr_q[LW-1:0]];
         inst_pc_d    = mem_pc_q[rd_ptr_q[LW-1:0]];
         inst_valid_d = 1'b1;
      end else if (!stall) begin
         inst_valid_d = 1'b0;
      end

      // Redirect wins over everything; a response still in flight must be dropped later.
      if (flush) begin
         rd_ptr_d     = wr_ptr_q;
         fetch_addr_d = flush_pc;
         inst_valid_d = 1'b0;
         if (pending_q && !fetch_valid) discard_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fetch_addr_q <= RESET_PC;
         req_addr_q   <= '0;
         pending_q    <= 1'b0;
         discard_q    <= 1'b0;
         started_q    <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         pending_q    <= pending_d;
         discard_q    <= discard_d;
         started_q    <= 1'b1;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   // NOTE: the entry storage has no reset; the pointers alone say which entries are live.
   always_ff @(posedge clk) begin
      if (push_w) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            mem_inst_q[wr_ptr_q[LW-1:0] + LW'(k)] <= fetch_data[k*IW +: IW];
            mem_pc_q[wr_ptr_q[LW-1:0] + LW'(k)]   <= req_addr_q + AW'(k * INST_BYTES);
         end
      end
   end

   assign fetch_addr = fetch_addr_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
   assign count      = count_w;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a memory responder plus a queue-level reference model,
// stepped one clock at a time, with scenario tasks adding their own targeted checks.
module tb_prefetch_queue;
   localparam int IW    = 16;
   localparam int LANES = 2;
   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam logic [AW-1:0] RESET_PC = '0;
   localparam int WB    = LANES * IW / 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   fetch_req;
   logic [AW-1:0]          fetch_addr;
   logic                   fetch_valid;
   logic [LANES*IW-1:0]    fetch_data;
   logic                   stall, flush;
   logic [AW-1:0]          flush_pc;
   logic [IW-1:0]          inst;
   logic [AW-1:0]          inst_pc;
   logic                   inst_valid;
   logic [$clog2(DEPTH):0] count;

   prefetch_queue #(.IW(IW), .LANES(LANES), .DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .stall(stall), .flush(flush),
      .flush_pc(flush_pc), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] i;
      logic [AW-1:0] pc;
   } entry_t;

   // Reference model: queue contents, output register, fetch bookkeeping.
   entry_t        mq[$];
   logic [IW-1:0] m_inst;
   logic [AW-1:0] m_pc, m_next, m_req;
   bit            m_valid, m_pending, m_discard, m_started;

   // Memory responder.
   bit            mem_busy;
   logic [AW-1:0] mem_addr;
   int            mem_due;
   int            lat_lo = 1, lat_hi = 1;
   bit            spur_en = 1'b0;
   logic [31:0]   salt = 32'h0;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   function automatic logic [IW-1:0] pat(input logic [AW-1:0] a);
      logic [31:0] t;
      t = (32'h1111_0000 | a) ^ salt;
      return t[IW-1:0];
   endfunction

   function automatic logic [LANES*IW-1:0] word(input logic [AW-1:0] a);
      logic [LANES*IW-1:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*IW +: IW] = pat(a + AW'(k * IW / 8));
      return w;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_inst = '0; m_pc = '0; m_valid = 1'b0;
      m_next = RESET_PC; m_req = '0;
      m_pending = 1'b0; m_discard = 1'b0; m_started = 1'b0;
   endtask

   // One clock: drive inputs at negedge, compare fetch outputs, advance the model, compare after the edge.
   task automatic step(input bit st, input bit fl, input logic [AW-1:0] fpc);
      bit resp, exp_req;
      entry_t e;
      logic [31:0] r;
      logic [$clog2(DEPTH):0] exp_cnt;
      @(negedge clk);
      stall = st; flush = fl; flush_pc = fpc;
      fetch_valid = 1'b0; fetch_data = '0;
      if (!rst && mem_busy && cyc >= mem_due) begin
         fetch_valid = 1'b1; fetch_data = word(mem_addr); mem_busy = 1'b0;
      end else if (!rst && !mem_busy && spur_en && $urandom_range(0, 5) == 0) begin
         r = $urandom; fetch_valid = 1'b1; fetch_data = r[LANES*IW-1:0];
      end
      #1;
      exp_req = !rst && m_started && !m_pending && !fl && (DEPTH - mq.size() >= LANES);
      total++;
      if (fetch_req !== exp_req)
         $display("FAIL fetch_req cyc=%0d got=%b exp=%b", cyc, fetch_req, exp_req);
      if (fetch_req !== exp_req) bad++;
      total++;
      if (fetch_addr !== m_next) begin
         bad++; $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", cyc, fetch_addr, m_next);
      end
      if (!rst && fetch_req === 1'b1) begin
         mem_busy = 1'b1; mem_addr = fetch_addr;
         mem_due = cyc + int'($urandom_range(lat_lo, lat_hi));
      end
      if (!rst) begin
         resp = fetch_valid && m_pending;
         if (fl) begin
            mq.delete(); m_valid = 1'b0; m_next = fpc;
            if (resp) begin m_pending = 1'b0; m_discard = 1'b0; end
            else if (m_pending) m_discard = 1'b1;
         end else begin
            if (!st) begin
               if (mq.size() > 0) begin
                  e = mq.pop_front(); m_inst = e.i; m_pc = e.pc; m_valid = 1'b1;
               end else m_valid = 1'b0;
            end
            if (resp) begin
               m_pending = 1'b0;
               if (m_discard) m_discard = 1'b0;
               else for (int k = 0; k < LANES; k++) begin
                  e.pc = m_req + AW'(k * IW / 8); e.i = pat(e.pc); mq.push_back(e);
               end
            end
            if (exp_req) begin m_pending = 1'b1; m_req = m_next; m_next = m_next + AW'(WB); end
         end
         m_started = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      exp_cnt = ($clog2(DEPTH)+1)'(mq.size());
      total++;
      if (inst_valid !== m_valid) begin
         bad++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, m_valid);
      end
      total++;
      if (inst !== m_inst || inst_pc !== m_pc) begin
         bad++; $display("FAIL inst cyc=%0d got=%h@%h exp=%h@%h", cyc, inst, inst_pc, m_inst, m_pc);
      end
      total++;
      if (count !== exp_cnt) begin
         bad++; $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, exp_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0; fetch_valid = 1'b0; fetch_data = '0;
      mem_busy = 1'b0;
      model_reset();
      #1;
      total++;
      if ({inst_valid, count, fetch_req} !== '0) begin
         bad++; $display("FAIL reset_flags got=%b/%0d/%b exp=0/0/0", inst_valid, count, fetch_req);
      end
      total++;
      if (inst !== '0 || inst_pc !== '0 || fetch_addr !== RESET_PC) begin
         bad++; $display("FAIL reset_regs got=%h@%h fa=%h exp=0@0 fa=%h", inst, inst_pc, fetch_addr, RESET_PC);
      end
      repeat (2) step(1'b0, 1'b0, '0);
      rst = 1'b0;
   endtask

   task automatic test_stream();
      bit seen = 1'b0;
      logic [AW-1:0] prev;
      lat_lo = 1; lat_hi = 1;
      for (int n = 0; n < 30; n++) begin
         step(1'b0, 1'b0, '0);
         if (!seen) begin
            if (inst_valid === 1'b1) begin
               seen = 1'b1; prev = RESET_PC; total++;
               if (inst_pc !== RESET_PC || inst !== pat(RESET_PC)) begin
                  bad++; $display("FAIL stream_first got=%h@%h exp=%h@%h", inst, inst_pc, pat(RESET_PC), RESET_PC);
               end
            end
         end else begin
            prev = prev + AW'(IW / 8); total++;
            if (inst_valid !== 1'b1 || inst_pc !== prev) begin
               bad++; $display("FAIL stream_seq got=%b@%h exp=1@%h", inst_valid, inst_pc, prev);
            end
         end
      end
      total++;
      if (!seen) begin bad++; $display("FAIL stream_fill got=no_issue exp=issue"); end
   endtask

   task automatic test_stall();
      logic [IW-1:0] fi; logic [AW-1:0] fp, prev; logic fv;
      bit hit = 1'b0;
      int n = 0;
      while (!(count == LANES && !m_pending) && n < 10) begin step(1'b0, 1'b0, '0); n++; end
      fi = inst; fp = inst_pc; fv = inst_valid;
      for (int s = 0; s < 10 && !hit; s++) begin
         step(1'b1, 1'b0, '0);
         total++;
         if ({inst_valid, inst, inst_pc} !== {fv, fi, fp}) begin
            bad++; $display("FAIL stall_frozen got=%b %h@%h exp=%b %h@%h", inst_valid, inst, inst_pc, fv, fi, fp);
         end
         if (count > DEPTH - LANES) begin
            total++;
            if (fetch_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", fetch_req); end
         end
         if (count == DEPTH) hit = 1'b1;
      end
      total++;
      if (!hit) begin bad++; $display("FAIL stall_fill got=%0d exp=%0d", count, DEPTH); end
      repeat (2) begin
         step(1'b1, 1'b0, '0);
         total++;
         if (count != DEPTH || fetch_req !== 1'b0) begin
            bad++; $display("FAIL stall_full got=%0d/%b exp=%0d/0", count, fetch_req, DEPTH);
         end
      end
      prev = fp;
      for (int s = 0; s < 12; s++) begin
         step(1'b0, 1'b0, '0);
         prev = prev + AW'(IW / 8); total++;
         if (inst_valid !== 1'b1 || inst_pc !== prev || inst !== pat(prev)) begin
            bad++; $display("FAIL stall_resume got=%b %h@%h exp=1 %h@%h", inst_valid, inst, inst_pc, pat(prev), prev);
         end
      end
   endtask

   task automatic test_flush_pending();
      bit done = 1'b0;
      int n = 0;
      lat_lo = 3; lat_hi = 3;
      while (!(m_pending && mem_busy && mem_due > cyc) && n < 10) begin step(1'b0, 1'b0, '0); n++; end
      step(1'b0, 1'b1, 32'h100);
      total++;
      if (inst_valid !== 1'b0 || count != 0 || fetch_addr !== 32'h100) begin
         bad++; $display("FAIL flush_pend got=%b/%0d/%h exp=0/0/100", inst_valid, count, fetch_addr);
      end
      for (int s = 0; s < 20 && !done; s++) begin
         step(1'b0, 1'b0, '0);
         if (inst_valid === 1'b1) begin
            done = 1'b1; total++;
            if (inst_pc !== 32'h100 || inst !== pat(32'h100)) begin
               bad++; $display("FAIL flush_first got=%h@%h exp=%h@100", inst, inst_pc, pat(32'h100));
            end
         end
      end
      total++;
      if (!done) begin bad++; $display("FAIL flush_refill got=no_issue exp=issue"); end
   endtask

   task automatic test_flush_coincident();
      int n = 0;
      lat_lo = 2; lat_hi = 2;
      while (!(mem_busy && mem_due == cyc) && n < 10) begin step(1'b0, 1'b0, '0); n++; end
      step(1'b1, 1'b1, 32'h100);
      total++;
      if (inst_valid !== 1'b0 || count != 0 || fetch_addr !== 32'h100) begin
         bad++; $display("FAIL flush_coin got=%b/%0d/%h exp=0/0/100", inst_valid, count, fetch_addr);
      end
      step(1'b0, 1'b0, '0);
      total++;
      if (fetch_addr !== 32'h104) begin
         bad++; $display("FAIL flush_coin_req got=%h exp=104", fetch_addr);
      end
   endtask

   task automatic test_latency3();
      bit have = 1'b0;
      logic [AW-1:0] prev;
      lat_lo = 3; lat_hi = 3;
      for (int s = 0; s < 60; s++) begin
         step(1'b0, 1'b0, '0);
         total++;
         if (count > DEPTH) begin bad++; $display("FAIL lat3_count got=%0d exp<=%0d", count, DEPTH); end
         if (inst_valid === 1'b1) begin
            if (have) begin
               total++;
               if (inst_pc !== prev + AW'(IW / 8)) begin
                  bad++; $display("FAIL lat3_seq got=%h exp=%h", inst_pc, prev + AW'(IW / 8));
               end
            end
            have = 1'b1; prev = inst_pc;
         end
      end
   endtask

   task automatic test_reset_mid();
      bit done = 1'b0;
      int n = 0;
      lat_lo = 3; lat_hi = 3;
      while (!m_pending && n < 10) begin step(1'b0, 1'b0, '0); n++; end
      @(negedge clk);
      stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({inst_valid, count, fetch_req} !== '0) begin
         bad++; $display("FAIL rstmid_flags got=%b/%0d/%b exp=0/0/0", inst_valid, count, fetch_req);
      end
      total++;
      if (inst !== '0 || inst_pc !== '0 || fetch_addr !== RESET_PC) begin
         bad++; $display("FAIL rstmid_regs got=%h@%h fa=%h exp=0@0 fa=%h", inst, inst_pc, fetch_addr, RESET_PC);
      end
      model_reset();
      @(posedge clk); #1;
      cyc++;
      repeat (2) step(1'b0, 1'b0, '0);
      rst = 1'b0;
      for (int s = 0; s < 20 && !done; s++) begin
         step(1'b0, 1'b0, '0);
         if (inst_valid === 1'b1) begin
            done = 1'b1; total++;
            if (inst_pc !== RESET_PC || inst !== pat(RESET_PC)) begin
               bad++; $display("FAIL rstmid_first got=%h@%h exp=%h@%h", inst, inst_pc, pat(RESET_PC), RESET_PC);
            end
         end
      end
      total++;
      if (!done) begin bad++; $display("FAIL rstmid_restart got=no_issue exp=issue"); end
   endtask

   task automatic test_random();
      bit st, fl;
      logic [AW-1:0] fpc;
      salt = 32'h0000_5A3C;
      lat_lo = 1; lat_hi = 4; spur_en = 1'b1;
      for (int s = 0; s < 400; s++) begin
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 24) == 0);
         fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'h3);
         step(st, fl, fpc);
         total++;
         if (count > DEPTH) begin bad++; $display("FAIL rand_count got=%0d exp<=%0d", count, DEPTH); end
      end
      spur_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush_pending();
      test_flush_coincident();
      test_latency3();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
